// File: rtl/width_unpacker_pkg.sv
// Shared types and helpers for the width unpacker.
package width_unpacker_pkg;

    // FSM state encoding: IDLE holds no word, EMIT streams slices of hold_q.
    typedef enum logic {
        StIdle = 1'b0,
        StEmit = 1'b1
    } state_e;

    // True when in_w splits into an integer number (>= 2) of out_w slices.
    function automatic bit ratio_legal(int unsigned in_w, int unsigned out_w);
        return (out_w != 0) && (in_w % out_w == 0) && (in_w / out_w >= 2);
    endfunction

endpackage

// File: rtl/width_unpacker_slice_mux.sv
// Combinational selector returning slice idx of a word, MSB-first or LSB-first.
module width_unpacker_slice_mux
    import width_unpacker_pkg::*;
#(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned OUT_W     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned RATIO    = IN_W / OUT_W,
    localparam int unsigned CNT_W    = $clog2(RATIO)
) (
    input  logic [IN_W-1:0]  word,
    input  logic [CNT_W-1:0] idx,
    output logic [OUT_W-1:0] slice
);

    logic [OUT_W-1:0] slices [RATIO];

    for (genvar k = 0; k < RATIO; k++) begin : g_slice
        if (MSB_FIRST) begin : g_msb
            assign slices[k] = word[IN_W-1-k*OUT_W -: OUT_W];
        end else begin : g_lsb
            assign slices[k] = word[k*OUT_W +: OUT_W];
        end
    end

    // Out-of-range indices (non power-of-two ratios) fall back to zero.
    always_comb begin
        slice = '0;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (idx == CNT_W'(k)) begin
                slice = slices[k];
            end
        end
    end

endmodule

// File: rtl/width_unpacker.sv
// Splits IN_W-bit words into OUT_W-bit slices on a valid/ready stream, one per clock.
module width_unpacker
    import width_unpacker_pkg::*;
#(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned OUT_W     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned RATIO = IN_W / OUT_W;
    localparam int unsigned CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(RATIO - 1);

    if (!ratio_legal(IN_W, OUT_W)) begin : g_bad_ratio
        $error("width_unpacker: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
    end

    state_e           state_q, state_d;
    logic [IN_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_raw;
    logic [OUT_W-1:0] slice;

    width_unpacker_slice_mux #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_slice_mux (
        .word  (hold_q),
        .idx   (cnt_q),
        .slice (slice)
    );

    // Next-state, handshake and output decode.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        in_ready_raw = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready_raw = 1'b1;
                if (in_valid) begin
                    hold_d  = in_data;
                    cnt_d   = '0;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                out_valid    = 1'b1;
                out_last     = (cnt_q == LastIdx);
                // Accept the next word on the same edge the last slice leaves: no bubble.
                in_ready_raw = out_ready && out_last;
                if (out_ready) begin
                    if (!out_last) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (in_valid) begin
                        hold_d = in_data;
                        cnt_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready = in_ready_raw & ~rst;
    assign out_data = out_valid ? slice : '0;
    assign busy     = (state_q == StEmit);

    // State, held word and slice index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
